// File: rtl/asrv32_clint_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// asrv32_clint_ctrl_pkg
// Shared definitions for the core-local interrupt controller (CLINT) slice:
// register word indices inside the 32-byte window, the bus FSM state
// encoding, the msip bit position and a byte-enable helper.
// No ports (package).
// -----------------------------------------------------------------------------
package asrv32_clint_ctrl_pkg;

  // Size of the decoded window in bytes; requests outside it are not ours.
  localparam int unsigned CLINT_SPAN_BYTES = 32;

  // Byte offsets of the architectural registers.
  localparam logic [4:0] OFF_MSIP        = 5'h00;
  localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] OFF_MTIME_LO    = 5'h10;
  localparam logic [4:0] OFF_MTIME_HI    = 5'h14;

  // Word indices (offset[4:2]) used by the decoder.
  localparam logic [2:0] W_MSIP        = OFF_MSIP[4:2];
  localparam logic [2:0] W_MTIMECMP_LO = OFF_MTIMECMP_LO[4:2];
  localparam logic [2:0] W_MTIMECMP_HI = OFF_MTIMECMP_HI[4:2];
  localparam logic [2:0] W_MTIME_LO    = OFF_MTIME_LO[4:2];
  localparam logic [2:0] W_MTIME_HI    = OFF_MTIME_HI[4:2];

  // Only this bit of msip is implemented.
  localparam int unsigned MSIP_BIT = 0;

  // Bus FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_ACK    = 2'd2
  } clint_state_e;

  // Writes only take effect when every byte lane is enabled.
  function automatic logic is_full_word(input logic [3:0] wsel);
    return (wsel == 4'hF);
  endfunction

endpackage

// File: rtl/asrv32_clint_ctrl_if.sv
// -----------------------------------------------------------------------------
// asrv32_clint_ctrl_if
// Data-memory bus as seen by the CLINT.
//   stb   : request strobe, held by the master until ack
//   we    : 1 = write, 0 = read
//   addr  : byte address
//   wdata : write data
//   wsel  : byte enables
//   ack   : one-cycle transfer acknowledge
//   rdata : read data, valid while ack = 1
// Modports: master (bus initiator), slave (the CLINT).
// -----------------------------------------------------------------------------
interface asrv32_clint_ctrl_if;
  logic        stb;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wsel;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output stb, we, addr, wdata, wsel,
    input  ack, rdata
  );

  modport slave (
    input  stb, we, addr, wdata, wsel,
    output ack, rdata
  );
endinterface

// File: rtl/asrv32_clint_timer.sv
// -----------------------------------------------------------------------------
// asrv32_clint_timer
// Local copy of the architectural timer: 64-bit mtime counter with a load
// port, the mtimecmp register with a load port, and a registered unsigned
// (mtime >= mtimecmp) flag.
//
// Optional macro ASRV32_CLINT_PRESCALE_EN:
//   defined   - mtime advances once per millisecond; a prescaler counts
//               0..CLK_FREQ_MHZ*1000-1 and ticks on wrap. It is cleared on
//               reset and whenever mtime is loaded.
//   undefined - mtime advances every clock; no prescaler exists.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_mtime_ld        load mtime with i_mtime_ld_val this cycle
//   i_mtime_ld_val    64-bit mtime load value
//   i_cmp_ld          load mtimecmp with i_cmp_ld_val this cycle
//   i_cmp_ld_val      64-bit mtimecmp load value
//   o_mtime           current mtime
//   o_mtimecmp        current mtimecmp
//   o_pending         registered mtime >= mtimecmp
// -----------------------------------------------------------------------------
module asrv32_clint_timer
  import asrv32_clint_ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ_MHZ = 100
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mtime_ld,
  input  logic [63:0] i_mtime_ld_val,
  input  logic        i_cmp_ld,
  input  logic [63:0] i_cmp_ld_val,
  output logic [63:0] o_mtime,
  output logic [63:0] o_mtimecmp,
  output logic        o_pending
);

  logic tick;

`ifdef ASRV32_CLINT_PRESCALE_EN
  localparam int unsigned TICKS_PER_MS = CLK_FREQ_MHZ * 1000;
  localparam int unsigned PRESC_W      = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

  logic [PRESC_W-1:0] presc_q, presc_d;

  assign tick = (presc_q == PRESC_W'(TICKS_PER_MS - 1));

  // A load restarts the millisecond so the new mtime value lasts a full tick.
  always_comb begin
    presc_d = presc_q + 1'b1;
    if (i_mtime_ld || tick) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  // Without the prescaler the clock frequency has no effect on the tick rate.
  localparam int unsigned UNUSED_CLK_FREQ_MHZ = CLK_FREQ_MHZ;
  assign tick = 1'b1;
`endif

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] cmp_q, cmp_d;
  logic        pending_q, pending_d;

  always_comb begin
    mtime_d   = mtime_q;
    cmp_d     = cmp_q;
    pending_d = (mtime_q >= cmp_q);
    // A load wins over a coincident tick; that tick is simply lost.
    if (i_mtime_ld) begin
      mtime_d = i_mtime_ld_val;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
    if (i_cmp_ld) begin
      cmp_d = i_cmp_ld_val;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mtime_q   <= '0;
      cmp_q     <= '1;
      pending_q <= 1'b0;
    end else begin
      mtime_q   <= mtime_d;
      cmp_q     <= cmp_d;
      pending_q <= pending_d;
    end
  end

  assign o_mtime    = mtime_q;
  assign o_mtimecmp = cmp_q;
  assign o_pending  = pending_q;

endmodule

// File: rtl/asrv32_clint_ctrl.sv
// -----------------------------------------------------------------------------
// asrv32_clint_ctrl
// Memory-mapped core-local interrupt controller sitting between the
// data-memory bus and the CSR unit. It owns the software view of msip,
// mtime and mtimecmp, turns two 32-bit writes into one atomic 64-bit update
// and forwards that update to the CSR unit once no CSR access is in flight.
//
// Register map (offset from BASE_ADDR, word aligned):
//   0x00 msip (bit 0)   0x08/0x0C mtimecmp lo/hi   0x10/0x14 mtime lo/hi
//   Other offsets inside the 32-byte window read 0 and ignore writes.
//
// Optional macro ASRV32_CLINT_PRESCALE_EN selects a millisecond mtime tick
// (see asrv32_clint_timer); by default mtime advances every clock.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   bus (slave modport)     stb/we/addr/wdata/wsel in, ack/rdata out
//   i_csr_stage_en          CSR unit busy with a CSR access; commits wait
//   o_mtime_wr_en/_din      one-cycle load pulse + value for CSR mtime
//   o_mtimecmp_wr_en/_din   one-cycle load pulse + value for CSR mtimecmp
//   o_software_interrupt    msip bit 0
//   o_timer_pending         registered mtime >= mtimecmp
// -----------------------------------------------------------------------------
module asrv32_clint_ctrl
  import asrv32_clint_ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ_MHZ = 100,
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  asrv32_clint_ctrl_if.slave   bus,
  input  logic                 i_csr_stage_en,
  output logic                 o_mtime_wr_en,
  output logic [63:0]          o_mtime_din,
  output logic                 o_mtimecmp_wr_en,
  output logic [63:0]          o_mtimecmp_din,
  output logic                 o_software_interrupt,
  output logic                 o_timer_pending
);

  clint_state_e state_q, state_d;

  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mtime_wr_q, mtime_wr_d;
  logic [63:0] mtime_din_q, mtime_din_d;
  logic        cmp_wr_q, cmp_wr_d;
  logic [63:0] cmp_din_q, cmp_din_d;
  logic        msip_q, msip_d;
  logic [31:0] shadow_mtime_lo_q, shadow_mtime_lo_d;
  logic [31:0] shadow_cmp_lo_q, shadow_cmp_lo_d;
  logic [31:0] snap_hi_q, snap_hi_d;
  logic [63:0] commit_val_q, commit_val_d;
  logic        commit_is_mtime_q, commit_is_mtime_d;

  logic [31:0] off;
  logic        hit;
  logic        aligned;
  logic [2:0]  word;
  logic        req;
  logic        wr_ok;
  logic        mtime_ld;
  logic        cmp_ld;
  logic [63:0] mtime_ld_val;
  logic [63:0] cmp_ld_val;
  logic [31:0] rd_val;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        pending;

  // Address decode. Misaligned offsets fall into the "unmapped" bucket:
  // acked, read as zero, writes dropped.
  assign off     = bus.addr - BASE_ADDR;
  assign hit     = (off[31:5] == 27'd0);
  assign aligned = (off[1:0] == 2'b00);
  assign word    = off[4:2];

  // A second request is not taken in the cycle ack is presented: the master
  // still holds stb there and only drops it after seeing ack.
  assign req   = bus.stb && hit && (state_q == ST_IDLE) && !ack_q;
  assign wr_ok = req && bus.we && aligned && is_full_word(bus.wsel);

  // The hi write is what makes a 64-bit update visible, combining with the
  // previously latched lo half.
  assign mtime_ld     = wr_ok && (word == W_MTIME_HI);
  assign cmp_ld       = wr_ok && (word == W_MTIMECMP_HI);
  assign mtime_ld_val = {bus.wdata, shadow_mtime_lo_q};
  assign cmp_ld_val   = {bus.wdata, shadow_cmp_lo_q};

  asrv32_clint_timer #(
    .CLK_FREQ_MHZ (CLK_FREQ_MHZ)
  ) u_timer (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_mtime_ld     (mtime_ld),
    .i_mtime_ld_val (mtime_ld_val),
    .i_cmp_ld       (cmp_ld),
    .i_cmp_ld_val   (cmp_ld_val),
    .o_mtime        (mtime),
    .o_mtimecmp     (mtimecmp),
    .o_pending      (pending)
  );

  // Read mux. mtime_hi returns the snapshot taken on the last mtime_lo read
  // so a lo-then-hi read pair never tears across a carry.
  always_comb begin
    rd_val = '0;
    if (aligned) begin
      case (word)
        W_MSIP:        rd_val[MSIP_BIT] = msip_q;
        W_MTIMECMP_LO: rd_val = mtimecmp[31:0];
        W_MTIMECMP_HI: rd_val = mtimecmp[63:32];
        W_MTIME_LO:    rd_val = mtime[31:0];
        W_MTIME_HI:    rd_val = snap_hi_q;
        default:       rd_val = '0;
      endcase
    end
  end

  always_comb begin
    state_d           = state_q;
    ack_d             = 1'b0;
    rdata_d           = rdata_q;
    mtime_wr_d        = 1'b0;
    mtime_din_d       = mtime_din_q;
    cmp_wr_d          = 1'b0;
    cmp_din_d         = cmp_din_q;
    msip_d            = msip_q;
    shadow_mtime_lo_d = shadow_mtime_lo_q;
    shadow_cmp_lo_d   = shadow_cmp_lo_q;
    snap_hi_d         = snap_hi_q;
    commit_val_d      = commit_val_q;
    commit_is_mtime_d = commit_is_mtime_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          // Read data is frozen here; ack presents it two cycles later.
          rdata_d = bus.we ? 32'd0 : rd_val;
          if (wr_ok) begin
            case (word)
              W_MSIP:        msip_d            = bus.wdata[MSIP_BIT];
              W_MTIMECMP_LO: shadow_cmp_lo_d   = bus.wdata;
              W_MTIME_LO:    shadow_mtime_lo_d = bus.wdata;
              default:       ;
            endcase
          end
          if (!bus.we && aligned && (word == W_MTIME_LO)) begin
            snap_hi_d = mtime[63:32];
          end
          if (mtime_ld || cmp_ld) begin
            state_d           = ST_COMMIT;
            commit_val_d      = mtime_ld ? mtime_ld_val : cmp_ld_val;
            commit_is_mtime_d = mtime_ld;
          end else begin
            state_d = ST_ACK;
          end
        end
      end

      ST_COMMIT: begin
        // The CSR unit cannot take a load while it is itself accessing CSRs.
        if (!i_csr_stage_en) begin
          state_d = ST_ACK;
          if (commit_is_mtime_q) begin
            mtime_wr_d  = 1'b1;
            mtime_din_d = commit_val_q;
          end else begin
            cmp_wr_d  = 1'b1;
            cmp_din_d = commit_val_q;
          end
        end
      end

      ST_ACK: begin
        ack_d   = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q           <= ST_IDLE;
      ack_q             <= 1'b0;
      rdata_q           <= '0;
      mtime_wr_q        <= 1'b0;
      mtime_din_q       <= '0;
      cmp_wr_q          <= 1'b0;
      cmp_din_q         <= '0;
      msip_q            <= 1'b0;
      shadow_mtime_lo_q <= '0;
      shadow_cmp_lo_q   <= '0;
      snap_hi_q         <= '0;
      commit_val_q      <= '0;
      commit_is_mtime_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      ack_q             <= ack_d;
      rdata_q           <= rdata_d;
      mtime_wr_q        <= mtime_wr_d;
      mtime_din_q       <= mtime_din_d;
      cmp_wr_q          <= cmp_wr_d;
      cmp_din_q         <= cmp_din_d;
      msip_q            <= msip_d;
      shadow_mtime_lo_q <= shadow_mtime_lo_d;
      shadow_cmp_lo_q   <= shadow_cmp_lo_d;
      snap_hi_q         <= snap_hi_d;
      commit_val_q      <= commit_val_d;
      commit_is_mtime_q <= commit_is_mtime_d;
    end
  end

  assign bus.ack              = ack_q;
  assign bus.rdata            = rdata_q;
  assign o_mtime_wr_en        = mtime_wr_q;
  assign o_mtime_din          = mtime_din_q;
  assign o_mtimecmp_wr_en     = cmp_wr_q;
  assign o_mtimecmp_din       = cmp_din_q;
  assign o_software_interrupt = msip_q;
  assign o_timer_pending      = pending;

endmodule
